unary_add_nch: RTL and testbench

Parametrised unary-stream accumulator and successor to the fixed 2-input, 12-bit unary adder. It counts the ones arriving on N_CH parallel unary bitstreams into a WIDTH-bit register, with a selectable wrap or saturate overflow policy and a sticky carry/overflow flag. On request it replays the accumulated total as a unary bitstream on `dout`, and flags completion with a one-cycle `done` pulse. It sits between unary/stochastic stream producers and downstream unary consumers or a binary readout (`count_o`).

---
 rtl/unary_add_nch.sv | 103 ++++++++++
 tb/tb_unary_add_nch.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/unary_add_nch.sv
// Unary-stream accumulator: counts ones on N_CH unary inputs into a WIDTH-bit
// register (wrap or saturate, sticky carry) and replays the total as a unary stream.
module unary_add_nch #(
  parameter int N_CH  = 2,
  parameter int WIDTH = 12,
  parameter bit SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             read_or_write,
  input  logic [N_CH-1:0]  din,
  output logic             dout,
  output logic             C,
  output logic             done,
  output logic [WIDTH-1:0] count_o
);

  localparam int PCW = $clog2(N_CH + 1);

  typedef enum logic [1:0] {ACC, READ, HOLD} state_t;

  state_t           state;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] rd_cnt;
  logic [PCW-1:0]   pc;
  logic [WIDTH:0]   sum;
  logic             ovf;

  function automatic logic [PCW-1:0] popcount(input logic [N_CH-1:0] v);
    logic [PCW-1:0] n;
    n = '0;
    for (int i = 0; i < N_CH; i++) n = n + PCW'(v[i]);
    return n;
  endfunction

  // Overflowed sums either drop the carry bit or pin to the all-ones value.
  function automatic logic [WIDTH-1:0] wrap_or_sat(input logic [WIDTH:0] s);
    if (SAT && s[WIDTH]) return '1;
    return s[WIDTH-1:0];
  endfunction

  always_comb begin
    pc  = popcount(din);
    sum = {1'b0, count} + (WIDTH+1)'(pc);
    ovf = sum[WIDTH];
  end

  assign count_o = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ACC;
      count  <= '0;
      rd_cnt <= '0;
      C      <= 1'b0;
      dout   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (en) begin
        // clr touches only the accumulator; a readout in flight keeps its latched length
        if (clr) begin
          count <= '0;
          C     <= 1'b0;
        end
        case (state)
          ACC: begin
            dout <= 1'b0;
            if (read_or_write) begin
              rd_cnt <= count;
              state  <= READ;
            end else if (!clr) begin
              count <= wrap_or_sat(sum);
              if (ovf) C <= 1'b1;
            end
          end
          READ: begin
            if (!read_or_write) begin
              dout   <= 1'b0;
              rd_cnt <= '0;
              state  <= ACC;
            end else if (rd_cnt != '0) begin
              dout   <= 1'b1;
              rd_cnt <= rd_cnt - WIDTH'(1);
            end else begin
              dout  <= 1'b0;
              done  <= 1'b1;
              state <= HOLD;
            end
          end
          HOLD: begin
            dout <= 1'b0;
            if (!read_or_write) state <= ACC;
          end
          default: state <= ACC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_unary_add_nch.sv
// Directed bench for unary_add_nch: wrap, saturate and 4-channel instances share
// control inputs; expected values are hand-computed.
module tb_unary_add_nch;

  logic       clk = 1'b0;
  logic       rst_n, en, clr, rw;
  logic [1:0] din2;
  logic [3:0] din4;

  logic        w_dout, w_c, w_done;
  logic [11:0] w_cnt;
  logic        s_dout, s_c, s_done;
  logic [11:0] s_cnt;
  logic        q_dout, q_c, q_done;
  logic [11:0] q_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  unary_add_nch #(.N_CH(2), .WIDTH(12), .SAT(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .read_or_write(rw),
    .din(din2), .dout(w_dout), .C(w_c), .done(w_done), .count_o(w_cnt));

  unary_add_nch #(.N_CH(2), .WIDTH(12), .SAT(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .read_or_write(rw),
    .din(din2), .dout(s_dout), .C(s_c), .done(s_done), .count_o(s_cnt));

  unary_add_nch #(.N_CH(4), .WIDTH(12), .SAT(1'b0)) u_ch4 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .read_or_write(rw),
    .din(din4), .dout(q_dout), .C(q_c), .done(q_done), .count_o(q_cnt));

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int hi_w, hi_q, dn_w, dn_q, at_w, at_q, bad_q, frz_bad;

  initial begin
    rst_n = 1'b0; en = 1'b1; clr = 1'b0; rw = 1'b0; din2 = '0; din4 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", w_cnt, 0);
    check("rst_c", w_c, 0);
    check("rst_dout", w_dout, 0);
    check("rst_done", w_done, 0);
    check("rst_sat_count", s_cnt, 0);
    rst_n = 1'b1;

    // 2049 pairs of (11, 00): 4098 ones total
    for (int p = 1; p <= 2049; p++) begin
      din2 = 2'b11;
      tick();
      if (p == 2048) begin
        check("wrap_at_4096", w_cnt, 0);
        check("wrap_c_rise", w_c, 1);
        check("sat_at_4096", s_cnt, 4095);
        check("sat_c_rise", s_c, 1);
      end
      din2 = 2'b00;
      tick();
      if (p == 2047) begin
        check("wrap_4094", w_cnt, 4094);
        check("wrap_c_pre", w_c, 0);
        check("sat_c_pre", s_c, 0);
      end
    end
    check("wrap_final", w_cnt, 2);
    check("wrap_final_c", w_c, 1);
    check("sat_final", s_cnt, 4095);
    din2 = 2'b11;
    repeat (3) tick();
    din2 = 2'b00;
    check("sat_stays", s_cnt, 4095);
    check("wrap_8", w_cnt, 8);

    // asynchronous reset in the middle of a readout
    rw = 1'b1;
    tick();
    tick();
    tick();
    check("pre_rst_dout", w_dout, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_dout", w_dout, 0);
    check("arst_done", w_done, 0);
    check("arst_c", w_c, 0);
    check("arst_count", w_cnt, 0);
    check("arst_sat_count", s_cnt, 0);
    check("arst_sat_c", s_c, 0);
    rw = 1'b0;
    #2;
    rst_n = 1'b1;

    // clr beats same-cycle accumulation
    din2 = 2'b11;
    repeat (3) tick();
    check("pre_clr", w_cnt, 6);
    clr = 1'b1;
    tick();
    clr = 1'b0; din2 = 2'b00;
    check("clr_count", w_cnt, 0);
    check("clr_c", w_c, 0);

    // 4 channels: 1011 for 10 cycles = 30
    din4 = 4'b1011;
    repeat (10) tick();
    din4 = 4'b0000;
    check("ch4_count", q_cnt, 30);

    // readout: ch4 K=30, wrap K=0 concurrently
    rw = 1'b1;
    tick();
    hi_w = 0; hi_q = 0; dn_w = 0; dn_q = 0; at_w = 0; at_q = 0; bad_q = 0;
    for (int i = 1; i <= 35; i++) begin
      tick();
      if (q_dout) hi_q++;
      if (q_dout !== (i <= 30)) bad_q++;
      if (q_done) begin dn_q++; at_q = i; end
      if (w_dout) hi_w++;
      if (w_done) begin dn_w++; at_w = i; end
    end
    check("ch4_hi", hi_q, 30);
    check("ch4_shape", bad_q, 0);
    check("ch4_done_n", dn_q, 1);
    check("ch4_done_at", at_q, 31);
    check("k0_hi", hi_w, 0);
    check("k0_done_n", dn_w, 1);
    check("k0_done_at", at_w, 1);
    rw = 1'b0;
    tick();
    check("ch4_nondestr", q_cnt, 30);

    // count=20 on the 2-channel instances
    din2 = 2'b11;
    repeat (10) tick();
    din2 = 2'b00;
    check("w_20", w_cnt, 20);

    // readout with en dropped for 5 cycles after 7 high cycles
    rw = 1'b1;
    tick();
    hi_w = 0; dn_w = 0; at_w = 0; frz_bad = 0;
    for (int i = 1; i <= 40; i++) begin
      en = !(i >= 8 && i <= 12);
      tick();
      if (en) begin
        if (w_dout) hi_w++;
        if (w_done) begin dn_w++; at_w = i; end
      end else if (w_dout !== 1'b1 || w_done !== 1'b0) begin
        frz_bad++;
      end
    end
    en = 1'b1;
    check("frz_hi", hi_w, 20);
    check("frz_hold", frz_bad, 0);
    check("frz_done_n", dn_w, 1);
    check("frz_done_at", at_w, 26);
    rw = 1'b0;
    tick();

    // readout aborted by dropping read_or_write after 7 high cycles
    rw = 1'b1;
    tick();
    hi_w = 0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (w_dout) hi_w++;
    end
    check("abort_pre_hi", hi_w, 7);
    rw = 1'b0;
    tick();
    check("abort_dout", w_dout, 0);
    dn_w = 0; hi_w = 0;
    if (w_done) dn_w++;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (w_done) dn_w++;
      if (w_dout) hi_w++;
    end
    check("abort_no_done", dn_w, 0);
    check("abort_dout_low", hi_w, 0);
    check("abort_count", w_cnt, 20);
    din2 = 2'b01;
    tick();
    din2 = 2'b00;
    check("abort_acc", w_cnt, 21);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
